// File: rtl/uart_px.sv
// UART with RX/TX serial engines and FIFOs, both clocked by a shared 16x-baud tick.
// Frame format and FIFO depths are fixed at build time.
module uart_px #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PARITY   = 0,
    parameter int unsigned STOP_W   = 1,
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en_16_x_baud,
    input  logic                        rx,
    output logic                        tx,
    output logic [DATA_W-1:0]           rxdata,
    output logic                        rx_perr,
    output logic                        rx_ferr,
    output logic                        rxdrdy,
    input  logic                        rd,
    output logic                        rx_ovf,
    input  logic                        clr_ovf,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    input  logic [DATA_W-1:0]           txdata,
    input  logic                        wr,
    output logic                        full,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        tx_busy
);

    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned RxW  = DATA_W + 2;

    localparam logic [TxAw:0] TxFull    = (TxAw + 1)'(TX_DEPTH);
    localparam logic [RxAw:0] RxFull    = (RxAw + 1)'(RX_DEPTH);
    localparam logic [3:0]    LastData  = 4'(DATA_W - 1);
    localparam logic [3:0]    LastStop  = 4'(STOP_W - 1);
    localparam logic          HasParity = (PARITY != 0);
    localparam logic          ParInv    = (PARITY == 1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TxAw-1:0]   tx_wptr_q, tx_rptr_q;
    logic [TxAw:0]     tx_level_q;
    logic              tx_push, tx_pop, tx_empty;
    logic [DATA_W-1:0] tx_head;

    assign full     = (tx_level_q == TxFull);
    assign tx_empty = (tx_level_q == '0);
    assign tx_head  = tx_mem[tx_rptr_q];
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign tx_push  = wr && (!full || tx_pop);
    assign tx_level = tx_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_level_q <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TxAw'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxAw'(1);
            if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + (TxAw + 1)'(1);
            else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - (TxAw + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= txdata;
    end

    // ---------------- TX engine ----------------
    tx_state_e         tx_state_q, tx_state_d;
    logic [3:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shr_q, tx_shr_d;
    logic              tx_par_q, tx_par_d;
    logic              tx_q, tx_d;
    logic              tx_load;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shr_d   = tx_shr_q;
        tx_par_d   = tx_par_q;
        tx_load    = 1'b0;
        tx_pop     = 1'b0;
        if (en_16_x_baud) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            unique case (tx_state_q)
                TxIdle: begin
                    tx_cnt_d = '0;
                    tx_load  = !tx_empty;
                end
                TxStart: begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_state_d = TxData;
                        tx_bit_d   = '0;
                    end
                end
                TxData: begin
                    if (tx_cnt_q == 4'd15) begin
                        if (tx_bit_q == LastData) begin
                            tx_state_d = HasParity ? TxParity : TxStop;
                            tx_bit_d   = '0;
                        end else begin
                            tx_bit_d = tx_bit_q + 4'd1;
                            tx_shr_d = tx_shr_q >> 1;
                        end
                    end
                end
                TxParity: begin
                    if (tx_cnt_q == 4'd15) begin
                        tx_state_d = TxStop;
                        tx_bit_d   = '0;
                    end
                end
                TxStop: begin
                    if (tx_cnt_q == 4'd15) begin
                        if (tx_bit_q == LastStop) begin
                            // Chain straight into the next frame to avoid an idle gap.
                            tx_state_d = TxIdle;
                            tx_load    = !tx_empty;
                        end else begin
                            tx_bit_d = tx_bit_q + 4'd1;
                        end
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
            if (tx_load) begin
                tx_pop     = 1'b1;
                tx_shr_d   = tx_head;
                tx_par_d   = (^tx_head) ^ ParInv;
                tx_state_d = TxStart;
                tx_cnt_d   = '0;
            end
        end
        unique case (tx_state_d)
            TxStart:  tx_d = 1'b0;
            TxData:   tx_d = tx_shr_d[0];
            TxParity: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shr_q   <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shr_q   <= tx_shr_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (tx_state_q != TxIdle) || !tx_empty;

    // ---------------- RX engine ----------------
    rx_state_e         rx_state_q, rx_state_d;
    logic              rx_meta_q, rx_sync_q;
    logic              rx_prev_q, rx_prev_d;
    logic [3:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]        rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shr_q, rx_shr_d;
    logic              rx_perr_q, rx_perr_d;
    logic              rx_we;
    logic [RxW-1:0]    rx_wdata;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_prev_d  = rx_prev_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shr_d   = rx_shr_q;
        rx_perr_d  = rx_perr_q;
        rx_we      = 1'b0;
        if (en_16_x_baud) begin
            // Tracked on every tick so a held-low line cannot retrigger a start.
            rx_prev_d = rx_sync_q;
            rx_cnt_d  = rx_cnt_q + 4'd1;
            unique case (rx_state_q)
                RxIdle: begin
                    rx_cnt_d = '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_d = RxStart;
                        rx_perr_d  = 1'b0;
                    end
                end
                RxStart: begin
                    if (rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_shr_d = {rx_sync_q, rx_shr_q[DATA_W-1:1]};
                        if (rx_bit_q == LastData) begin
                            rx_state_d = HasParity ? RxParity : RxStop;
                        end else begin
                            rx_bit_d = rx_bit_q + 4'd1;
                        end
                    end
                end
                RxParity: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_perr_d  = rx_sync_q ^ (^rx_shr_q) ^ ParInv;
                        rx_state_d = RxStop;
                    end
                end
                RxStop: begin
                    if (rx_cnt_q == 4'd15) begin
                        rx_we      = 1'b1;
                        rx_state_d = RxIdle;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    assign rx_wdata = {~rx_sync_q, rx_perr_q, rx_shr_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shr_q   <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shr_q   <= rx_shr_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [RxW-1:0]  rx_mem [RX_DEPTH];
    logic [RxAw-1:0] rx_wptr_q, rx_rptr_q;
    logic [RxAw:0]   rx_level_q;
    logic            rx_ovf_q, rx_ovf_d;
    logic            rx_push, rx_pop, rx_full, rx_drop;
    logic [RxW-1:0]  rx_head;

    assign rx_full = (rx_level_q == RxFull);
    assign rx_pop  = rd && (rx_level_q != '0);
    assign rx_push = rx_we && (!rx_full || rx_pop);
    assign rx_drop = rx_we && rx_full && !rx_pop;

    always_comb begin
        rx_ovf_d = rx_ovf_q;
        if (rx_drop)      rx_ovf_d = 1'b1;
        else if (clr_ovf) rx_ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_level_q <= '0;
            rx_ovf_q   <= 1'b0;
        end else begin
            rx_ovf_q <= rx_ovf_d;
            if (rx_push) rx_wptr_q <= rx_wptr_q + RxAw'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RxAw'(1);
            if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + (RxAw + 1)'(1);
            else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - (RxAw + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wptr_q] <= rx_wdata;
    end

    // Head is masked while empty so the outputs read zero rather than stale storage.
    assign rx_head  = rxdrdy ? rx_mem[rx_rptr_q] : '0;
    assign rxdrdy   = (rx_level_q != '0);
    assign rxdata   = rx_head[DATA_W-1:0];
    assign rx_perr  = rx_head[DATA_W];
    assign rx_ferr  = rx_head[DATA_W+1];
    assign rx_ovf   = rx_ovf_q;
    assign rx_level = rx_level_q;

endmodule

// File: tb/tb_uart_px.sv
// Directed bench for uart_px: three builds (8N1 default, even-parity small FIFOs in
// loopback, odd parity), expected RX words and TX bits held in scoreboard queues.
module tb_uart_px;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    int checks = 0;
    int errors = 0;

    int tick_div = 4;
    int bit_clks = 64;
    bit tick_run = 1'b1;
    int tick_cnt = 0;

    logic [9:0] exp_q[$];
    logic       bit_q[$];

    // dut_a: defaults (8N1, 16/16)
    logic       rx_a = 1'b1;
    logic       tx_a;
    logic [7:0] rxdata_a;
    logic       rx_perr_a, rx_ferr_a, rxdrdy_a, rx_ovf_a, full_a, tx_busy_a;
    logic       rd_a = 1'b0, clr_ovf_a = 1'b0, wr_a = 1'b0;
    logic [4:0] rx_level_a, tx_level_a;
    logic [7:0] txdata_a = 8'h00;

    // dut_b: even parity, 4-deep FIFOs, tx looped back to rx
    logic       tx_b;
    logic [7:0] rxdata_b;
    logic       rx_perr_b, rx_ferr_b, rxdrdy_b, rx_ovf_b, full_b, tx_busy_b;
    logic       rd_b = 1'b0, clr_ovf_b = 1'b0, wr_b = 1'b0;
    logic [2:0] rx_level_b, tx_level_b;
    logic [7:0] txdata_b = 8'h00;

    // dut_c: odd parity, rx driven by the bench
    logic       rx_c = 1'b1;
    logic       tx_c;
    logic [7:0] rxdata_c;
    logic       rx_perr_c, rx_ferr_c, rxdrdy_c, rx_ovf_c, full_c, tx_busy_c;
    logic       rd_c = 1'b0, clr_ovf_c = 1'b0, wr_c = 1'b0;
    logic [4:0] rx_level_c, tx_level_c;
    logic [7:0] txdata_c = 8'h00;

    uart_px u_dut_a (
        .clk(clk), .rst(rst), .en_16_x_baud(en), .rx(rx_a), .tx(tx_a),
        .rxdata(rxdata_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rxdrdy(rxdrdy_a),
        .rd(rd_a), .rx_ovf(rx_ovf_a), .clr_ovf(clr_ovf_a), .rx_level(rx_level_a),
        .txdata(txdata_a), .wr(wr_a), .full(full_a), .tx_level(tx_level_a),
        .tx_busy(tx_busy_a)
    );

    uart_px #(.PARITY(2), .TX_DEPTH(4), .RX_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .en_16_x_baud(en), .rx(tx_b), .tx(tx_b),
        .rxdata(rxdata_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rxdrdy(rxdrdy_b),
        .rd(rd_b), .rx_ovf(rx_ovf_b), .clr_ovf(clr_ovf_b), .rx_level(rx_level_b),
        .txdata(txdata_b), .wr(wr_b), .full(full_b), .tx_level(tx_level_b),
        .tx_busy(tx_busy_b)
    );

    uart_px #(.PARITY(1)) u_dut_c (
        .clk(clk), .rst(rst), .en_16_x_baud(en), .rx(rx_c), .tx(tx_c),
        .rxdata(rxdata_c), .rx_perr(rx_perr_c), .rx_ferr(rx_ferr_c), .rxdrdy(rxdrdy_c),
        .rd(rd_c), .rx_ovf(rx_ovf_c), .clr_ovf(clr_ovf_c), .rx_level(rx_level_c),
        .txdata(txdata_c), .wr(wr_c), .full(full_c), .tx_level(tx_level_c),
        .tx_busy(tx_busy_c)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_run) begin
            tick_cnt = tick_cnt + 1;
            if (tick_cnt >= tick_div) tick_cnt = 0;
            en = (tick_cnt == 0);
        end else begin
            en = 1'b0;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [9:0] got);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(got), 32'(e));
        end
    endtask

    function automatic logic drdy_of(input int sel);
        case (sel)
            0:       return rxdrdy_a;
            1:       return rxdrdy_b;
            default: return rxdrdy_c;
        endcase
    endfunction

    function automatic logic [9:0] head_of(input int sel);
        case (sel)
            0:       return {rx_ferr_a, rx_perr_a, rxdata_a};
            1:       return {rx_ferr_b, rx_perr_b, rxdata_b};
            default: return {rx_ferr_c, rx_perr_c, rxdata_c};
        endcase
    endfunction

    task automatic read_rx(input int sel, input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (drdy_of(sel)) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_rdy"}, 32'(seen), 32'd1);
        if (seen) begin
            sb_check(tag, head_of(sel));
            case (sel)
                0:       rd_a = 1'b1;
                1:       rd_b = 1'b1;
                default: rd_c = 1'b1;
            endcase
            @(negedge clk);
            rd_a = 1'b0;
            rd_b = 1'b0;
            rd_c = 1'b0;
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic tx_write(input int sel, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (!(sel == 0 ? full_a : full_b)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("tx_write_ready", 32'(ok), 32'd1);
        if (sel == 0) begin
            txdata_a = d;
            wr_a = 1'b1;
        end else begin
            txdata_b = d;
            wr_b = 1'b1;
        end
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else rx_c = v;
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, bits[i]);
            repeat (bit_clks) @(negedge clk);
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic wait_idle_b(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!tx_busy_b) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [7:0] t1_bytes [2];
        bit found;
        int sent;
        int got;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1);
        chk("rst_rxdrdy", rxdrdy_a, 0);
        chk("rst_rx_ovf", rx_ovf_a, 0);
        chk("rst_full", full_a, 0);
        chk("rst_tx_busy", tx_busy_a, 0);
        chk("rst_rx_level", rx_level_a, 0);
        chk("rst_tx_level", tx_level_a, 0);
        chk("rst_rxdata", rxdata_a, 0);
        chk("rst_perr", rx_perr_a, 0);
        chk("rst_ferr", rx_ferr_a, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // ---- T1: 8N1 frames, 0x55 then 0xA3, back to back ----
        t1_bytes[0] = 8'h55;
        t1_bytes[1] = 8'hA3;
        for (int f = 0; f < 2; f++) begin
            bit_q.push_back(1'b0);
            for (int b = 0; b < 8; b++) bit_q.push_back(t1_bytes[f][b]);
            bit_q.push_back(1'b1);
        end
        tx_write(0, 8'h55);
        tx_write(0, 8'hA3);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_a == 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t1_start_seen", 32'(found), 32'd1);
        for (int k = 0; k < 20; k++) begin
            repeat (k == 0 ? 32 : 64) @(negedge clk);
            chk($sformatf("t1_bit%0d", k), tx_a, bit_q.pop_front());
        end
        repeat (22) @(negedge clk);
        chk("t1_busy_in_stop", tx_busy_a, 1);
        repeat (20) @(negedge clk);
        chk("t1_busy_done", tx_busy_a, 0);
        chk("t1_tx_idle", tx_a, 1);
        chk("t1_tx_level", tx_level_a, 0);

        // ---- T7: 3-tick glitch is ignored ----
        rx_a = 1'b0;
        repeat (3 * tick_div) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * bit_clks) @(negedge clk);
        chk("t7_no_write", rxdrdy_a, 0);
        chk("t7_level", rx_level_a, 0);

        // ---- T3: odd parity error then framing error ----
        exp_q.push_back({2'b01, 8'h3C});
        exp_q.push_back({2'b10, 8'h3C});
        send_bits(2, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
        send_bits(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        repeat (bit_clks) @(negedge clk);
        chk("t3_level", rx_level_c, 2);
        read_rx(2, "t3_perr", 64);
        read_rx(2, "t3_ferr", 64);

        // ---- break: one ferr byte, no restart while rx stays low ----
        exp_q.push_back({2'b10, 8'h00});
        rx_a = 1'b0;
        repeat (30 * bit_clks) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * bit_clks) @(negedge clk);
        chk("brk_level", rx_level_a, 1);
        read_rx(0, "brk_byte", 64);
        repeat (bit_clks) @(negedge clk);
        chk("brk_single", rx_level_a, 0);

        // ---- T6: reset in the middle of TX and RX frames ----
        tx_write(0, 8'h00);
        rx_a = 1'b0;
        repeat (3 * bit_clks) @(negedge clk);
        chk("t6_tx_low_pre", tx_a, 0);
        rst = 1'b1;
        rx_a = 1'b1;
        #1;
        chk("t6_tx_async", tx_a, 1);
        chk("t6_tx_busy", tx_busy_a, 0);
        chk("t6_tx_level", tx_level_a, 0);
        chk("t6_rxdrdy", rxdrdy_a, 0);
        chk("t6_rx_level", rx_level_a, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (bit_clks) @(negedge clk);
        exp_q.push_back({2'b00, 8'hA5});
        send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        repeat (bit_clks) @(negedge clk);
        read_rx(0, "t6_clean", 64);

        // ---- faster ticks for the loopback runs ----
        tick_div = 1;
        bit_clks = 16;
        repeat (40) @(negedge clk);

        // ---- T2: 0x00..0xFF loopback with even parity ----
        sent = 0;
        got = 0;
        for (int cyc = 0; cyc < 60000 && got < 256; cyc++) begin
            @(negedge clk);
            wr_b = 1'b0;
            rd_b = 1'b0;
            if (rxdrdy_b) begin
                sb_check($sformatf("t2_byte%0d", got), head_of(1));
                rd_b = 1'b1;
                got++;
            end
            if (sent < 256 && !full_b) begin
                txdata_b = 8'(sent);
                wr_b = 1'b1;
                exp_q.push_back({2'b00, 8'(sent)});
                sent++;
            end
        end
        @(negedge clk);
        wr_b = 1'b0;
        rd_b = 1'b0;
        chk("t2_count", 32'(got), 32'd256);
        exp_q.delete();
        wait_idle_b("t2_idle", 2000);
        repeat (40) @(negedge clk);

        // ---- T4: RX overflow with a 4-deep FIFO ----
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back({2'b00, 8'(8'h11 + i)});
            tx_write(1, 8'(8'h11 + i));
        end
        wait_idle_b("t4_idle", 3000);
        repeat (40) @(negedge clk);
        chk("t4_level", rx_level_b, 4);
        chk("t4_ovf", rx_ovf_b, 1);
        for (int i = 0; i < 4; i++) read_rx(1, $sformatf("t4_read%0d", i), 16);
        chk("t4_ovf_sticky", rx_ovf_b, 1);
        clr_ovf_b = 1'b1;
        @(negedge clk);
        clr_ovf_b = 1'b0;
        chk("t4_ovf_clr", rx_ovf_b, 0);
        rd_b = 1'b1;
        @(negedge clk);
        rd_b = 1'b0;
        chk("t4_rd_empty", rx_level_b, 0);

        // ---- T5: full TX FIFO with ticks stopped ----
        tick_run = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                chk("t5_full", full_b, 1);
                chk("t5_level4", tx_level_b, 4);
            end else begin
                exp_q.push_back({2'b00, 8'(8'h40 + i)});
            end
            txdata_b = 8'(8'h40 + i);
            wr_b = 1'b1;
            @(negedge clk);
            wr_b = 1'b0;
        end
        chk("t5_level_after_drop", tx_level_b, 4);
        chk("t5_busy_stalled", tx_busy_b, 1);
        tick_run = 1'b1;
        for (int i = 0; i < 4; i++) read_rx(1, $sformatf("t5_frame%0d", i), 400);
        wait_idle_b("t5_idle", 1000);
        repeat (40) @(negedge clk);
        chk("t5_no_fifth", rxdrdy_b, 0);
        chk("t5_no_ovf", rx_ovf_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
